bram_sp_clrinit: RTL and testbench
==================================

Name: bram_sp_clrinit

Overview:
- Parametrised single-port block RAM; next generation of the team's 64x16 block RAM with output clear.
- Adds the following:
  - generic width and depth
  - per-byte write enables
  - selectable read-during-write mode
  - a read-valid flag
  - a background FSM that initialises every word to INIT_VAL after reset or on request.
- Used wherever a module needs scratch memory with a guaranteed known content.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 6, address width; depth = 2**ADDR_W words.
- MODE, 0, read-during-write behaviour: 0 read-first, 1 write-first, 2 no-change.
- INIT_VAL, 0, DATA_W-bit value written to every word by the init FSM.

Ports:
- CLK  in  1  clock; all logic on posedge.
- CLR  in  1  synchronous active-high reset.
- en  in  1  port enable; access only when 1 and busy=0.
- we  in  DATA_W/8  byte write enables; bit i covers DI[8i+7:8i].
- addr  in  ADDR_W  word address.
- DI  in  DATA_W  write data.
- init_req  in  1  request to re-initialise the whole memory.
- DO  out  DATA_W  registered read data.
- DO_valid  out  1  DO updated by an accepted read in the previous cycle.
- busy  out  1  init FSM active; user accesses ignored.

Behaviour:
- Reset (CLR=1 at posedge):
  - DO=0, DO_valid=0, busy=1.
  - FSM enters INIT with init pointer ptr=0.
  - CLR has priority over everything, including a mid-init state; init restarts at ptr 0.
  - Memory contents are not touched while CLR is held.
- FSM states: IDLE, INIT.
- INIT, each cycle with CLR=0:
  - RAM[ptr] <= INIT_VAL, then ptr++.
  - When ptr = 2**ADDR_W-1, write the final word and go to IDLE.
  - busy is 0 from the first cycle after the last write.
  - Init therefore takes exactly 2**ADDR_W cycles after CLR falls.
- In INIT:
  - en, we and init_req are ignored.
  - DO holds its value; DO_valid=0.
- IDLE + init_req=1 (en ignored that cycle): next state INIT, ptr=0, busy=1. A duplicate init_req while in INIT is ignored.
- IDLE + en=1, init_req=0:
  - Byte writes: for each set we[i], RAM[addr] byte i <= DI byte i; other bytes unchanged.
  - Read result on DO one cycle later (latency 1), DO_valid=1 that cycle, according to MODE:
    - MODE 0: DO = pre-write word.
    - MODE 1: DO = merged post-write word (new bytes where we set, old bytes elsewhere).
    - MODE 2: if any we bit is set, DO holds and DO_valid=0; otherwise a normal read.
- IDLE + en=0: DO holds, DO_valid=0; no write even if we≠0.
- Address wrap: ptr is ADDR_W bits and stops at max; a user addr is always in range (full decode).
- Illegal MODE value (>2): behaves as MODE 0.

Optional Feature:
- Macro: BRAM_OUTREG_EN.
- Defined:
  - An extra output pipeline register after the array register.
  - Read latency is 2; DO_valid is delayed to match.
  - CLR zeroes both stages.
  - In INIT the second stage still drains one cycle; DO_valid is 0 once the pipeline is empty.
- Undefined: latency 1 as above.

Test Plan:
- Reset/init (DATA_W=16, ADDR_W=4, INIT_VAL=16'hA5A5):
  - Pulse CLR 1 cycle → DO=0 and DO_valid=0 immediately; busy=1 for exactly 16 cycles.
  - Then read every address → all 16'hA5A5, DO_valid=1 one cycle after each en.
- Byte enables:
  - Write addr 3 DI=16'h1234 we=2'b11, then DI=16'hFFFF we=2'b01.
  - Read addr 3 → DO=16'h12FF.
- Read-during-write:
  - addr 5 holds 16'h0F0F; write 16'hBEEF we=2'b11 with en=1.
  - Next cycle DO must be 16'h0F0F for MODE 0, 16'hBEEF for MODE 1, and held with DO_valid=0 for MODE 2.
- Access during init:
  - Assert init_req, then during busy attempt a write of 16'h5555 to addr 2.
  - After busy falls, addr 2 reads INIT_VAL; DO_valid stays 0 throughout busy.
- Reset mid-init:
  - Assert CLR when ptr=7 → init restarts and busy lasts a full 16 cycles after CLR falls.
  - All words read INIT_VAL.
- With BRAM_OUTREG_EN defined:
  - Read addr 3 (16'h12FF) → DO and DO_valid appear exactly 2 cycles after en.
  - CLR mid-read → DO=0 next cycle.

Source files
------------

// File: rtl/bram_sp_clrinit.sv
// rtl/bram_sp_clrinit.sv - single-port block RAM with byte enables and background init to INIT_VAL
// Optional macro BRAM_OUTREG_EN adds a second output register (read latency 2).
module bram_sp_clrinit #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 6,
   parameter int                MODE     = 0,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                CLK,
   input  logic                CLR,
   input  logic                en,
   input  logic [DATA_W/8-1:0] we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   DI,
   input  logic                init_req,
   output logic [DATA_W-1:0]   DO,
   output logic                DO_valid,
   output logic                busy
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;
   // Out-of-range MODE values fall back to read-first.
   localparam int EMODE = (MODE == 1 || MODE == 2) ? MODE : 0;

   typedef enum logic {S_IDLE, S_INIT} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   ptr;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                start_init;
   logic                last_word;
   logic                acc;
   logic                rd_acc;
   logic [DATA_W-1:0]   rd_old;
   logic [DATA_W-1:0]   rd_merged;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   do_q;
   logic                vld_q;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state <= S_INIT;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         if (start_init)
            ptr <= '0;
         else if (state == S_INIT && !last_word)
            ptr <= ptr + ADDR_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_INIT:  if (last_word)  state_nx = S_IDLE;
         S_IDLE:  if (init_req)   state_nx = S_INIT;
         default: state_nx = S_INIT;
      endcase
   end

   always_comb begin
      busy       = (state == S_INIT);
      last_word  = &ptr;
      start_init = (state == S_IDLE) && init_req;
      acc        = (state == S_IDLE) && en && !init_req;
      // No-change mode suppresses the read whenever any byte is written.
      rd_acc     = acc && !(EMODE == 2 && |we);
   end

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         if (state == S_INIT) begin
            mem[ptr] <= INIT_VAL;
         end else if (acc) begin
            for (int i = 0; i < NB; i++)
               if (we[i]) mem[addr][8*i +: 8] <= DI[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_old = mem[addr];
      for (int i = 0; i < NB; i++)
         rd_merged[8*i +: 8] = we[i] ? DI[8*i +: 8] : rd_old[8*i +: 8];
      rd_data = (EMODE == 1) ? rd_merged : rd_old;
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         do_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= rd_acc;
         if (rd_acc) do_q <= rd_data;
      end
   end

`ifdef BRAM_OUTREG_EN
   always_ff @(posedge CLK) begin
      if (CLR) begin
         DO       <= '0;
         DO_valid <= 1'b0;
      end else begin
         DO_valid <= vld_q;
         if (vld_q) DO <= do_q;
      end
   end
`else
   assign DO       = do_q;
   assign DO_valid = vld_q;
`endif

endmodule

// File: tb/tb_bram_sp_clrinit.sv
// tb/tb_bram_sp_clrinit.sv - directed checks of bram_sp_clrinit in all three read-during-write modes
module tb_bram_sp_clrinit;

   logic        CLK = 1'b0;
   logic        CLR, en, init_req;
   logic [1:0]  we;
   logic [3:0]  addr;
   logic [15:0] DI;
   logic [15:0] do0, do1, do2;
   logic        dv0, dv1, dv2;
   logic        bz0, bz1, bz2;

   int checks = 0;
   int errors = 0;
   int n;

   typedef struct {
      logic        en;
      logic [1:0]  we;
      logic [3:0]  a;
      logic [15:0] di;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [15:0] d2;
      logic        v2;
   } vec_t;

   vec_t tv[11];

   bram_sp_clrinit #(.DATA_W(16), .ADDR_W(4), .MODE(0), .INIT_VAL(16'hA5A5)) u_m0 (
      .CLK(CLK), .CLR(CLR), .en(en), .we(we), .addr(addr), .DI(DI),
      .init_req(init_req), .DO(do0), .DO_valid(dv0), .busy(bz0));
   bram_sp_clrinit #(.DATA_W(16), .ADDR_W(4), .MODE(1), .INIT_VAL(16'hA5A5)) u_m1 (
      .CLK(CLK), .CLR(CLR), .en(en), .we(we), .addr(addr), .DI(DI),
      .init_req(init_req), .DO(do1), .DO_valid(dv1), .busy(bz1));
   bram_sp_clrinit #(.DATA_W(16), .ADDR_W(4), .MODE(2), .INIT_VAL(16'hA5A5)) u_m2 (
      .CLK(CLK), .CLR(CLR), .en(en), .we(we), .addr(addr), .DI(DI),
      .init_req(init_req), .DO(do2), .DO_valid(dv2), .busy(bz2));

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic v0, input logic v1, input logic v2);
      chk({nm, " DO m0"}, {16'h0, do0}, {16'h0, e0});
      chk({nm, " DO m1"}, {16'h0, do1}, {16'h0, e1});
      chk({nm, " DO m2"}, {16'h0, do2}, {16'h0, e2});
      chk({nm, " DO_valid m0"}, {31'h0, dv0}, {31'h0, v0});
      chk({nm, " DO_valid m1"}, {31'h0, dv1}, {31'h0, v1});
      chk({nm, " DO_valid m2"}, {31'h0, dv2}, {31'h0, v2});
   endtask

   // One-cycle access, then wait out the read latency before the caller checks.
   task automatic access(input logic e, input logic [1:0] w, input logic [3:0] a, input logic [15:0] d);
      en = e; we = w; addr = a; DI = d;
      tick;
      en = 1'b0; we = 2'b00;
`ifdef BRAM_OUTREG_EN
      chk("pipe gap valid m0", {31'h0, dv0}, 32'h0);
      chk("pipe gap valid m1", {31'h0, dv1}, 32'h0);
      tick;
`endif
   endtask

   task automatic wait_init(input bit poke, input logic [15:0] hold, output int cnt);
      cnt = 0;
      while (bz0 && cnt < 100) begin
         if (poke) begin
            en = 1'b1; we = 2'b11; addr = 4'd2; DI = 16'h5555;
         end
         chk("init DO_valid m0", {31'h0, dv0}, 32'h0);
         chk("init DO_valid m1", {31'h0, dv1}, 32'h0);
         chk("init DO hold m0", {16'h0, do0}, {16'h0, hold});
         tick;
         cnt++;
      end
      en = 1'b0; we = 2'b00;
      chk("busy m1 done", {31'h0, bz1}, 32'h0);
      chk("busy m2 done", {31'h0, bz2}, 32'h0);
   endtask

   task automatic read_all(input string nm);
      for (int a = 0; a < 16; a++) begin
         access(1'b1, 2'b00, 4'(a), 16'h0);
         chk_out(nm, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 1'b1, 1'b1);
      end
   endtask

   initial begin
      tv[0]  = '{1'b1, 2'b11, 4'd3,  16'h1234, 16'hA5A5, 16'h1234, 16'hA5A5, 1'b0};
      tv[1]  = '{1'b1, 2'b01, 4'd3,  16'hFFFF, 16'h1234, 16'h12FF, 16'hA5A5, 1'b0};
      tv[2]  = '{1'b1, 2'b00, 4'd3,  16'h0000, 16'h12FF, 16'h12FF, 16'h12FF, 1'b1};
      tv[3]  = '{1'b1, 2'b11, 4'd5,  16'h0F0F, 16'hA5A5, 16'h0F0F, 16'h12FF, 1'b0};
      tv[4]  = '{1'b1, 2'b00, 4'd5,  16'h0000, 16'h0F0F, 16'h0F0F, 16'h0F0F, 1'b1};
      tv[5]  = '{1'b1, 2'b11, 4'd5,  16'hBEEF, 16'h0F0F, 16'hBEEF, 16'h0F0F, 1'b0};
      tv[6]  = '{1'b1, 2'b00, 4'd5,  16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b1};
      tv[7]  = '{1'b0, 2'b11, 4'd9,  16'h9999, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0};
      tv[8]  = '{1'b1, 2'b00, 4'd9,  16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1};
      tv[9]  = '{1'b1, 2'b10, 4'd15, 16'h3C00, 16'hA5A5, 16'h3CA5, 16'hA5A5, 1'b0};
      tv[10] = '{1'b1, 2'b00, 4'd15, 16'h0000, 16'h3CA5, 16'h3CA5, 16'h3CA5, 1'b1};

      CLR = 1'b1; en = 1'b0; init_req = 1'b0; we = 2'b00; addr = 4'd0; DI = 16'h0;
      tick;
      chk_out("reset", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("reset busy", {29'h0, bz0, bz1, bz2}, 32'h7);
      CLR = 1'b0;
      wait_init(1'b0, 16'h0, n);
      chk("reset init cycles", n, 32'd16);
      read_all("post-reset read");

      for (int i = 0; i < 11; i++) begin
         access(tv[i].en, tv[i].we, tv[i].a, tv[i].di);
         chk_out($sformatf("vec%0d", i), tv[i].d0, tv[i].d1, tv[i].d2, tv[i].en, tv[i].en, tv[i].v2);
      end

      init_req = 1'b1;
      tick;
      init_req = 1'b0;
      chk("init_req busy", {31'h0, bz0}, 32'h1);
      wait_init(1'b1, 16'h3CA5, n);
      chk("init_req cycles", n, 32'd16);
      access(1'b1, 2'b00, 4'd2, 16'h0);
      chk_out("addr2 after init", 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 1'b1, 1'b1);
      access(1'b1, 2'b00, 4'd3, 16'h0);
      chk_out("addr3 after init", 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 1'b1, 1'b1);

      access(1'b1, 2'b11, 4'd12, 16'h1111);
      init_req = 1'b1;
      tick;
      init_req = 1'b0;
      for (int k = 0; k < 7; k++) tick;
      CLR = 1'b1;
      tick;
      chk_out("clr mid-init", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("clr mid-init busy", {31'h0, bz0}, 32'h1);
      CLR = 1'b0;
      wait_init(1'b0, 16'h0, n);
      chk("restart init cycles", n, 32'd16);
      read_all("post-restart read");

      access(1'b1, 2'b11, 4'd3, 16'h12FF);
      access(1'b1, 2'b00, 4'd3, 16'h0);
      chk_out("latency read addr3", 16'h12FF, 16'h12FF, 16'h12FF, 1'b1, 1'b1, 1'b1);

      en = 1'b1; addr = 4'd3;
      tick;
      en = 1'b0;
      CLR = 1'b1;
      tick;
      chk_out("clr mid-read", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      CLR = 1'b0;
      wait_init(1'b0, 16'h0, n);
      chk("final init cycles", n, 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
